seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_scan.sv | 116 +++++++++++
 tb/tb_seg7_scan.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODES_OFF = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low segment pattern; codes 10..15 show a dash.
// The blank flag overrides the digit entirely.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode scan driver with per-slot guard,
// frame-coherent digit snapshot, leading-zero blanking and blinking dp.
module seg7_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] num0,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic       blank_lz,
    input  logic       dp_blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    import seg7_pkg::*;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GEND = PW'(GUARD);
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              blink_q, blink_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic              blz_q, blz_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              wrap;
    logic              frame_start;
    logic [3:0]        blank;
    logic [6:0]        dec_seg;

    assign wrap        = (pcnt_q == PMAX);
    assign frame_start = (slot_q == 2'd0) && (pcnt_q == '0);

    // A digit is blank only if every digit to its left is blank too
    assign blank[3] = blz_q && (snap_q[3] == 4'd0);
    assign blank[2] = blank[3] && (snap_q[2] == 4'd0);
    assign blank[1] = blank[2] && (snap_q[1] == 4'd0);
    assign blank[0] = 1'b0;

    seg7_decode u_decode (
        .digit (snap_q[slot_q]),
        .blank (blank[slot_q]),
        .seg   (dec_seg)
    );

    always_comb begin
        pcnt_d  = wrap ? '0 : pcnt_q + 1'b1;
        slot_d  = wrap ? slot_q + 2'd1 : slot_q;
        frame_d = frame_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        blz_d   = blz_q;
        if (wrap && slot_q == 2'd3) begin
            if (frame_q == FMAX) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        if (frame_start) begin
            snap_d = {num3, num2, num1, num0};
            blz_d  = blank_lz;
        end
        an_d  = ANODES_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (pcnt_q >= GEND) begin
            an_d  = ~(4'b0001 << slot_q);
            seg_d = dec_seg;
            dp_d  = ~((slot_q == 2'd2) && (!dp_blink_en || blink_q));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q  <= '0;
            slot_q  <= 2'd0;
            frame_q <= '0;
            blink_q <= 1'b1;
            snap_q  <= '0;
            blz_q   <= 1'b0;
            an_q    <= ANODES_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            pcnt_q  <= pcnt_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a short 8-cycle slot,
// 2-cycle guard and 2-frame blink half-period.
module tb_seg7_scan;

    localparam int RD = 8;
    localparam int GD = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] num0, num1, num2, num3;
    logic       blank_lz, dp_blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .REFRESH_DIV  (RD),
        .GUARD        (GD),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .num0        (num0),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .blank_lz    (blank_lz),
        .dp_blink_en (dp_blink_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Must be entered at a frame-start cycle; checks all 32 cycles.
    task automatic run_frame(input string name,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic dp_on);
        logic [6:0] segs [4];
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        int p, s;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int i = 0; i < 4 * RD; i++) begin
            @(posedge clk); #1;
            p = i % RD;
            s = i / RD;
            if (p < GD) begin
                ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
            end else begin
                ean  = ~(4'b0001 << s);
                eseg = segs[s];
                edp  = (s == 2 && dp_on) ? 1'b0 : 1'b1;
            end
            chk($sformatf("%s c%0d an", name, i), {4'h0, an}, {4'h0, ean});
            chk($sformatf("%s c%0d seg", name, i), {1'b0, seg}, {1'b0, eseg});
            chk($sformatf("%s c%0d dp", name, i), {7'h0, dp}, {7'h0, edp});
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        num3 = 4'd3; num2 = 4'd2; num1 = 4'd1; num0 = 4'd0;
        blank_lz    = 1'b0;
        dp_blink_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an", {4'h0, an}, 8'h0F);
        chk("rst seg", {1'b0, seg}, 8'h7F);
        chk("rst dp", {7'h0, dp}, 8'h01);
        reset_n = 1'b1;

        run_frame("basic", 7'h40, 7'h79, 7'h24, 7'h30, 1'b1);

        num0 = 4'd5;
        fork
            run_frame("coh_a", 7'h12, 7'h79, 7'h24, 7'h30, 1'b1);
            begin
                repeat (20) @(posedge clk);
                #2 num0 = 4'd6;
            end
        join
        run_frame("coh_b", 7'h02, 7'h79, 7'h24, 7'h30, 1'b1);

        blank_lz = 1'b1;
        num3 = 4'd0; num2 = 4'd0; num1 = 4'd0; num0 = 4'd7;
        run_frame("lz_0007", 7'h78, 7'h7F, 7'h7F, 7'h7F, 1'b1);
        num0 = 4'd0;
        run_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);
        num2 = 4'd1;
        run_frame("lz_0100", 7'h40, 7'h40, 7'h79, 7'h7F, 1'b1);

        blank_lz = 1'b0;
        num2 = 4'd0; num1 = 4'd12;
        run_frame("inv", 7'h40, 7'h3F, 7'h40, 7'h40, 1'b1);
        blank_lz = 1'b1;
        run_frame("inv_lz", 7'h40, 7'h3F, 7'h7F, 7'h7F, 1'b1);

        // Land mid slot 1 of the next frame, then reset asynchronously
        blank_lz = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        chk("pre_rst an", {4'h0, an}, 8'h0D);
        reset_n = 1'b0;
        #1;
        chk("async an", {4'h0, an}, 8'h0F);
        chk("async seg", {1'b0, seg}, 8'h7F);
        chk("async dp", {7'h0, dp}, 8'h01);
        num3 = 4'd9; num2 = 4'd8; num1 = 4'd7; num0 = 4'd6;
        dp_blink_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_frame("blink f0", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);
        run_frame("blink f1", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);
        run_frame("blink f2", 7'h02, 7'h78, 7'h00, 7'h10, 1'b0);
        run_frame("blink f3", 7'h02, 7'h78, 7'h00, 7'h10, 1'b0);
        run_frame("blink f4", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);
        run_frame("blink f5", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);

        dp_blink_en = 1'b0;
        run_frame("steady f6", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);
        run_frame("steady f7", 7'h02, 7'h78, 7'h00, 7'h10, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
